// File: rtl/mux2to1_rr_arbiter.sv
// rtl/mux2to1_rr_arbiter.sv - two-port valid/ready round-robin arbiter with bounded bursts and a registered output
//
// Purpose: shares one output stream between two valid/ready producers. The current
// owner keeps the path for up to BURST back-to-back beats while the other port is
// waiting. A single output register gives 1-cycle latency at full throughput.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in0_valid  port 0 has a beat
//   in0_data   port 0 payload
//   in0_ready  port 0 beat accepted this cycle (combinational)
//   in1_valid  port 1 has a beat
//   in1_data   port 1 payload
//   in1_ready  port 1 beat accepted this cycle (combinational)
//   out_valid  output register holds a beat
//   out_data   output payload
//   out_ready  downstream accepts out_data this cycle
//   out_sel    source port of the beat in out_data
//   s          current owner of the path
module mux2to1_rr_arbiter #(
  parameter int WIDTH = 8,
  parameter int BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in0_valid,
  input  logic [WIDTH-1:0] in0_data,
  output logic             in0_ready,
  input  logic             in1_valid,
  input  logic [WIDTH-1:0] in1_data,
  output logic             in1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             out_sel,
  output logic             s
);

  localparam int             CW      = $clog2(BURST + 1);
  localparam logic [CW-1:0]  C_BURST = CW'(BURST);
  localparam logic [CW-1:0]  C_ONE   = CW'(1);

  logic             r_s;
  logic [CW-1:0]    r_cnt;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_sel;

  logic             w_load;
  logic             w_own_valid;
  logic             w_oth_valid;
  logic             w_pick;
  logic             w_pick_valid;
  logic [WIDTH-1:0] w_pick_data;
  logic             w_xfer;
  logic             w_s_next;
  logic [CW-1:0]    w_cnt_next;

  // Output register is free when empty or being drained this cycle.
  assign w_load      = !r_out_valid || out_ready;
  assign w_own_valid = r_s ? in1_valid : in0_valid;
  assign w_oth_valid = r_s ? in0_valid : in1_valid;

  // Owner keeps the path until its burst budget is spent and the other port waits.
  always_comb begin
    w_pick = r_s;
    if (w_own_valid && (!w_oth_valid || (r_cnt < C_BURST))) begin
      w_pick = r_s;
    end else if (w_oth_valid) begin
      w_pick = ~r_s;
    end
  end

  assign w_pick_valid = w_pick ? in1_valid : in0_valid;
  assign w_pick_data  = w_pick ? in1_data  : in0_data;
  assign w_xfer       = w_load && w_pick_valid;

  // Readies are forced low while reset is held, since the empty register would
  // otherwise advertise a free slot.
  assign in0_ready = rst_n && w_load && !w_pick;
  assign in1_ready = rst_n && w_load &&  w_pick;

  always_comb begin
    w_s_next   = r_s;
    w_cnt_next = r_cnt;
    if (w_xfer) begin
      if (w_pick == r_s) begin
        if (r_cnt != C_BURST) begin
          w_cnt_next = r_cnt + C_ONE;
        end
      end else begin
        w_s_next   = w_pick;
        w_cnt_next = C_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s         <= 1'b0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= 1'b0;
    end else begin
      r_s   <= w_s_next;
      r_cnt <= w_cnt_next;
      if (w_xfer) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_pick_data;
        r_out_sel   <= w_pick;
      end else if (w_load) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;
  assign s         = r_s;

endmodule

// File: tb/tb_mux2to1_rr_arbiter.sv
// tb/tb_mux2to1_rr_arbiter.sv - self-checking bench for mux2to1_rr_arbiter
module tb_mux2to1_rr_arbiter;

  localparam int W = 8;
  localparam int B = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in0_valid, in1_valid, in0_ready, in1_ready;
  logic [W-1:0] in0_data, in1_data, out_data;
  logic         out_valid, out_ready, out_sel, s;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] seq0, seq1;

  mux2to1_rr_arbiter #(.WIDTH(W), .BURST(B)) dut (
    .clk(clk), .rst_n(rst_n),
    .in0_valid(in0_valid), .in0_data(in0_data), .in0_ready(in0_ready),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(in1_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .out_sel(out_sel), .s(s)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         v0;
    logic [W-1:0] d0;
    logic         v1;
    logic [W-1:0] d1;
    logic         ordy;
    logic         er0;
    logic         er1;
    logic         eov;
    logic [W-1:0] eod;
    logic         eos;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b0;
    in0_data = '0; in1_data = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One cycle, entered and left 1 time unit after a rising edge.
  task automatic cyc(input logic v0, input logic v1, input logic ordy,
                     output logic r0, output logic r1);
    in0_valid = v0; in1_valid = v1; out_ready = ordy;
    in0_data = seq0; in1_data = seq1;
    #1;
    r0 = in0_ready; r1 = in1_ready;
    @(posedge clk); #1;
    if (r0 && v0) seq0 = seq0 + 1'b1;
    if (r1 && v1) seq1 = seq1 + 1'b1;
  endtask

  initial begin
    logic r0, r1;
    logic [W-1:0] k0, k1, hd;
    logic hs;

    tbl[0]  = '{1'b1, 8'h11, 1'b1, 8'h21, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0};
    tbl[1]  = '{1'b1, 8'h12, 1'b1, 8'h21, 1'b1, 1'b1, 1'b0, 1'b1, 8'h12, 1'b0};
    tbl[2]  = '{1'b1, 8'h13, 1'b1, 8'h21, 1'b1, 1'b1, 1'b0, 1'b1, 8'h13, 1'b0};
    tbl[3]  = '{1'b1, 8'h14, 1'b1, 8'h21, 1'b1, 1'b1, 1'b0, 1'b1, 8'h14, 1'b0};
    tbl[4]  = '{1'b1, 8'h15, 1'b1, 8'h21, 1'b1, 1'b0, 1'b1, 1'b1, 8'h21, 1'b1};
    tbl[5]  = '{1'b1, 8'h15, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 8'h21, 1'b1};
    tbl[6]  = '{1'b1, 8'h15, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 1'b1, 8'h22, 1'b1};
    tbl[7]  = '{1'b0, 8'h15, 1'b0, 8'h23, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[8]  = '{1'b1, 8'h15, 1'b0, 8'h23, 1'b1, 1'b1, 1'b0, 1'b1, 8'h15, 1'b0};
    tbl[9]  = '{1'b0, 8'h16, 1'b1, 8'h23, 1'b0, 1'b0, 1'b0, 1'b1, 8'h15, 1'b0};
    tbl[10] = '{1'b0, 8'h16, 1'b1, 8'h23, 1'b1, 1'b0, 1'b1, 1'b1, 8'h23, 1'b1};

    // Reset state
    do_reset();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_s", s, 0);

    // Table-driven vectors
    for (int i = 0; i < 11; i++) begin
      in0_valid = tbl[i].v0; in0_data = tbl[i].d0;
      in1_valid = tbl[i].v1; in1_data = tbl[i].d1;
      out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("vec%0d_in0_ready", i), in0_ready, tbl[i].er0);
      chk($sformatf("vec%0d_in1_ready", i), in1_ready, tbl[i].er1);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_out_valid", i), out_valid, tbl[i].eov);
      if (tbl[i].eov) begin
        chk($sformatf("vec%0d_out_data", i), out_data, tbl[i].eod);
        chk($sformatf("vec%0d_out_sel", i), out_sel, tbl[i].eos);
      end
    end

    // 1: asynchronous reset mid-stream, then a port 1 beat
    do_reset();
    seq0 = 8'h30; seq1 = 8'h40;
    repeat (3) cyc(1'b1, 1'b1, 1'b1, r0, r1);
    chk("t1_pre_out_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("t1_out_valid", out_valid, 0);
    chk("t1_s", s, 0);
    chk("t1_out_sel", out_sel, 0);
    chk("t1_in0_ready", in0_ready, 0);
    chk("t1_in1_ready", in1_ready, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    in0_valid = 1'b0; in1_valid = 1'b1; in1_data = 8'h5A; out_ready = 1'b1;
    #1;
    chk("t1_in1_ready_after", in1_ready, 1);
    @(posedge clk); #1;
    chk("t1_out_valid_after", out_valid, 1);
    chk("t1_out_data_after", out_data, 8'h5A);
    chk("t1_out_sel_after", out_sel, 1);

    // 2: single port streams without bubbles
    do_reset();
    seq0 = 8'h01; seq1 = 8'h80;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b0, 1'b1, r0, r1);
      chk("t2_in1_ready", r1, 0);
      chk("t2_out_valid", out_valid, 1);
      chk("t2_out_data", out_data, 8'(i + 1));
      chk("t2_s", s, 0);
    end

    // 3: contention gives BURST beats per port in turn
    do_reset();
    seq0 = 8'h00; seq1 = 8'h80;
    k0 = 8'h00; k1 = 8'h80;
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 1'b1, 1'b1, r0, r1);
      chk("t3_out_sel", out_sel, (i / B) % 2);
      if (((i / B) % 2) == 0) begin
        chk("t3_out_data0", out_data, k0); k0 = k0 + 1'b1;
      end else begin
        chk("t3_out_data1", out_data, k1); k1 = k1 + 1'b1;
      end
    end

    // 4: backpressure holds output and readies low, no loss or duplication
    hd = out_data; hs = out_sel;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b1, 1'b0, r0, r1);
      chk("t4_in0_ready", r0, 0);
      chk("t4_in1_ready", r1, 0);
      chk("t4_out_valid", out_valid, 1);
      chk("t4_out_data_hold", out_data, hd);
      chk("t4_out_sel_hold", out_sel, hs);
    end
    cyc(1'b1, 1'b1, 1'b1, r0, r1);
    chk("t4_resume_sel", out_sel, 0);
    chk("t4_resume_data", out_data, k0);

    // 5: late requester after a saturated burst
    do_reset();
    seq0 = 8'h00; seq1 = 8'h80;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 1'b0, 1'b1, r0, r1);
      chk("t5_in0_beat", out_data, 8'(i));
    end
    cyc(1'b1, 1'b1, 1'b1, r0, r1);
    chk("t5_first_in1_sel", out_sel, 1);
    chk("t5_first_in1_data", out_data, 8'h80);
    chk("t5_s", s, 1);
    for (int i = 1; i < B; i++) begin
      cyc(1'b1, 1'b1, 1'b1, r0, r1);
      chk("t5_in1_burst", out_sel, 1);
    end
    cyc(1'b1, 1'b1, 1'b1, r0, r1);
    chk("t5_back_to_0", out_sel, 0);
    chk("t5_back_to_0_data", out_data, 8'h06);

    // 6: randomised traffic against a grant-history reference model
    do_reset();
    seq0 = 8'h00; seq1 = 8'h80;
    begin
      int   hist[$];
      logic m_ov, m_os, v0, v1, ordy, load, own, vown, voth, pick, xfer;
      logic [W-1:0] m_od;
      int   run, w0, w1;
      m_ov = 1'b0; m_od = '0; m_os = 1'b0; w0 = 0; w1 = 0;
      for (int c = 0; c < 10000; c++) begin
        v0   = ($urandom_range(0, 3) != 0);
        v1   = ($urandom_range(0, 3) != 0);
        ordy = ($urandom_range(0, 3) != 0);
        own  = (hist.size() == 0) ? 1'b0 : hist[hist.size() - 1][0];
        run  = 0;
        for (int j = hist.size() - 1; j >= 0 && run < B; j--) begin
          if (hist[j] == int'(own)) run++;
          else break;
        end
        load = !m_ov || ordy;
        vown = own ? v1 : v0;
        voth = own ? v0 : v1;
        if (vown && (!voth || run < B)) pick = own;
        else if (voth) pick = !own;
        else pick = own;
        xfer = load && (pick ? v1 : v0);

        in0_valid = v0; in1_valid = v1; out_ready = ordy;
        in0_data = seq0; in1_data = seq1;
        #1;
        chk("t6_in0_ready", in0_ready, load && !pick);
        chk("t6_in1_ready", in1_ready, load && pick);
        @(posedge clk); #1;

        if (xfer) begin
          m_ov = 1'b1; m_os = pick; m_od = pick ? seq1 : seq0;
          hist.push_back(int'(pick));
          if (hist.size() > B + 1) void'(hist.pop_front());
          if (pick) seq1 = seq1 + 1'b1; else seq0 = seq0 + 1'b1;
        end else if (load) begin
          m_ov = 1'b0;
        end

        // Beats granted to the other port while this one keeps waiting.
        if (!v0 || (xfer && !pick)) w0 = 0;
        else if (xfer && pick) begin w0++; chk("t6_starve0", (w0 <= B), 1); end
        if (!v1 || (xfer && pick)) w1 = 0;
        else if (xfer && !pick) begin w1++; chk("t6_starve1", (w1 <= B), 1); end

        chk("t6_out_valid", out_valid, m_ov);
        if (m_ov) begin
          chk("t6_out_data", out_data, m_od);
          chk("t6_out_sel", out_sel, m_os);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
